// File: rtl/gf8_horner_eval.sv
`default_nettype none
// ============================================================================
// Module   : gf8_horner_eval
// Brief    : Sequential GF(2^3) polynomial evaluator using Horner's rule,
//            acc <= acc*x ^ c, one coefficient per accepted beat.
// Revision : 1.0  initial release
// ============================================================================
module gf8_horner_eval #(
    parameter int         CNT_W    = 4,
    parameter logic [2:0] RED_POLY = 3'b011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       x_in,
    input  logic [CNT_W-1:0] n_coef,
    input  logic             coef_valid,
    input  logic [2:0]       coef_data,
    output logic             coef_ready,
    output logic             result_valid,
    output logic [2:0]       result,
    input  logic             result_ready,
    output logic             busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_acc;
    logic [2:0]       r_x;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       w_product;

    // Carry-less 3x3 product, then fold x^4 and x^3 back using RED_POLY.
    // x^4 is folded first because its reduction can set the x^3 term.
    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p;
        p = 5'd0;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) begin
                p = p ^ ({2'b00, a} << i);
            end
        end
        for (int k = 4; k >= 3; k--) begin
            if (p[k]) begin
                p[k] = 1'b0;
                p    = p ^ ({2'b00, RED_POLY} << (k - 3));
            end
        end
        return p[2:0];
    endfunction

    assign w_product = gf_mul(r_acc, r_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_acc   <= 3'd0;
            r_x     <= 3'd0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_acc <= 3'd0;
                        if (n_coef != '0) begin
                            r_x     <= x_in;
                            r_count <= n_coef;
                            r_state <= c_st_load;
                        end else begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_load: begin
                    if (coef_valid) begin
                        r_acc   <= w_product ^ coef_data;
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    if (result_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // result is the accumulator itself, so it holds its value in IDLE
    assign coef_ready   = (r_state == c_st_load);
    assign result_valid = (r_state == c_st_done);
    assign busy         = (r_state == c_st_load) || (r_state == c_st_done);
    assign result       = r_acc;

endmodule
`default_nettype wire
